text_console_ctrl: RTL and testbench
====================================

Name: text_console_ctrl

Overview:
Write-side controller for the 80x30 text tile RAM (12-bit address {row[4:0], col[6:0]}, 7-bit ASCII data) feeding the text screen generator. It accepts a stream of ASCII characters over a valid/ready handshake and owns the cursor. It translates control codes into sequences of tile-RAM writes: print, newline, backspace, row clear and full-screen clear. It drives the write port (port A) of the dual-port video RAM and exports the cursor position for reverse-video display.

Parameters:
MAX_X, 80, columns per row
MAX_Y, 30, rows per screen
ADDR_WIDTH, 12, tile RAM address width ({5-bit row, 7-bit col})
DATA_WIDTH, 7, character code width
BLANK, 7'h20, code written by all clear operations

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
ch_data  in  7  ASCII character
ch_valid  in  1  ch_data valid
ch_ready  out  1  controller can accept; combinational from state (1 only in IDLE)
we  out  1  tile RAM write enable (registered)
addr_w  out  12  tile RAM write address {row, col} (registered)
din  out  7  tile RAM write data (registered)
cur_x  out  7  cursor column
cur_y  out  5  cursor row
busy  out  1  high in any clear state

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high.
- Reset values: state=CLR_ALL, cur_x=0, cur_y=0, we=0, addr_w=0, din=0, clear counters=0, ch_ready=0, busy=1.
- A transfer happens on any rising edge where ch_valid && ch_ready. ch_data is sampled on that edge. we/addr_w/din are visible in the following cycle.
- States:
  - CLR_ALL: one write per cycle of BLANK, row 0..MAX_Y-1, col 0..MAX_X-1, in address order. That is 2400 cycles, then IDLE with cursor (0,0).
  - IDLE: accepts characters, one per cycle (back-to-back allowed).
  - CLR_ROW: one write per cycle of BLANK to {cur_y, 0..MAX_X-1}, then IDLE.
- Character decode in IDLE on a transfer:
  - Printable 0x20..0x7E: we=1, addr_w={cur_y,cur_x}, din=ch_data. If cur_x<MAX_X-1, then cur_x+1. If cur_x==MAX_X-1, do a newline after the write.
  - 0x0A (LF) or 0x0D (CR): newline. cur_x=0. cur_y=cur_y+1, or 0 if cur_y==MAX_Y-1 (wrap, no scroll). Go to CLR_ROW, clearing the new row. No character write.
  - 0x08 (BS): if cur_x>0, cur_x-1 and write BLANK at the new position (one cycle). If cur_x==0, no write and no move.
  - 0x0C (FF): cursor (0,0), then CLR_ALL.
  - All other codes: consumed, no effect.
- Column-wrap printable: the character write occupies cycle T+1 and the row clear starts at T+2. ch_ready is low from T+1 until the last clear write.
- Busy duration: CLR_ROW runs exactly MAX_X write cycles; CLR_ALL runs exactly MAX_X*MAX_Y.
- ch_ready=0 and busy=1 throughout both clear states. Input is back-pressured, never dropped.
- The clear address never exceeds MAX_X-1 / MAX_Y-1. Columns 80..127 and rows 30..31 are never written.
- we deasserts the cycle after the last write of any sequence.
- Reset asserted mid-operation aborts immediately and restarts CLR_ALL from address 0.
- Cursor arithmetic is width-exact: 7-bit column, 5-bit row, with explicit compares against MAX-1. Natural overflow is not relied on.

Decomposition:
- Package text_console_pkg holds:
  - MAX_X and MAX_Y
  - char codes: CH_BS=8'h08, CH_LF=0x0A, CH_FF=0x0C, CH_CR=0x0D
  - BLANK
  - the state encoding (CLR_ALL, IDLE, CLR_ROW)
- One natural sub-module: tile_clear_seq, a row/column counter with start, whole_screen/single_row mode, row-select input, and done output. It generates the clear addresses.
- The parent holds the FSM, cursor and decode.

Test Plan:
1. Release reset: exactly 2400 writes, din=0x20, addresses 0x000..0x04F, 0x080..0x0CF, …, 0xE80..0xECF; then ch_ready=1 and cursor (0,0).
2. Send 'A' (0x41) then 'B' back-to-back: writes {addr 0x000, 0x41} and {0x001, 0x42} on consecutive cycles; cursor (2,0).
3. Send 80 printables from (0,0): the last is written at 0x04F; then 80 BLANK writes at 0x080..0x0CF; cursor (0,1); ch_ready low for exactly those 81 cycles.
4. At cur_y=29, send 0x0A: cursor (0,0), 80 BLANK writes at 0x000..0x04F, no character write.
5. At (5,3) send 0x08: single write {0x184, 0x20}, cursor (4,3). At (0,3) send 0x08: no write, cursor unchanged.
6. Send 0x0C; assert reset after 100 clear writes: we=0 asynchronously; after release, the clear restarts at 0x000 with a full 2400 writes; cursor (0,0).

Source files
------------

// File: rtl/text_console_pkg.sv
// ---------------------------------------------------------------------------
// text_console_pkg
// Shared constants, character codes and state encoding for the text console
// write-side controller and its clear sequencer.
// ---------------------------------------------------------------------------
package text_console_pkg;

  localparam int unsigned ADDR_WIDTH = 12;
  localparam int unsigned DATA_WIDTH = 7;

  // Screen geometry and the last legal index in each dimension
  localparam logic [6:0] MAX_X    = 7'd80;
  localparam logic [4:0] MAX_Y    = 5'd30;
  localparam logic [6:0] LAST_COL = MAX_X - 7'd1;
  localparam logic [4:0] LAST_ROW = MAX_Y - 5'd1;

  // Code written by every clear operation
  localparam logic [6:0] BLANK = 7'h20;

  // Control codes (7-bit, matching the character path width)
  localparam logic [6:0] CH_BS = 7'h08;
  localparam logic [6:0] CH_LF = 7'h0A;
  localparam logic [6:0] CH_FF = 7'h0C;
  localparam logic [6:0] CH_CR = 7'h0D;

  // Printable range
  localparam logic [6:0] CH_PRINT_LO = 7'h20;
  localparam logic [6:0] CH_PRINT_HI = 7'h7E;

  typedef enum logic [1:0] {
    CLR_ALL = 2'd0,
    IDLE    = 2'd1,
    CLR_ROW = 2'd2
  } state_e;

  function automatic logic is_printable(input logic [6:0] c);
    return (c >= CH_PRINT_LO) && (c <= CH_PRINT_HI);
  endfunction

  // Row after r, wrapping from the last row back to row 0 (no scrolling)
  function automatic logic [4:0] next_row(input logic [4:0] r);
    return (r == LAST_ROW) ? 5'd0 : (r + 5'd1);
  endfunction

endpackage

// File: rtl/text_console_ctrl_clear_seq.sv
// ---------------------------------------------------------------------------
// tile_clear_seq
// Row/column counter producing one clear address per cycle, either for the
// whole screen (rows 0..MAX_Y-1) or for a single selected row.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   start_i      load a new sequence (column 0, row 0 or row_i)
//   whole_i      1: whole screen, 0: single row row_i
//   row_i        row to clear in single-row mode
//   active_o     current row_o/col_o is a clear address to write this cycle
//   row_o,col_o  clear address
//   done_o       one-cycle pulse the cycle after the last address
// Out of reset a whole-screen sequence is already running from address 0.
// ---------------------------------------------------------------------------
module tile_clear_seq
  import text_console_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic       whole_i,
  input  logic [4:0] row_i,
  output logic       active_o,
  output logic [4:0] row_o,
  output logic [6:0] col_o,
  output logic       done_o
);

  logic       run_q,   run_d;
  logic       whole_q, whole_d;
  logic [4:0] row_q,   row_d;
  logic [6:0] col_q,   col_d;
  logic       done_q,  done_d;

  // Next-state for the clear counters
  always_comb begin
    run_d   = run_q;
    whole_d = whole_q;
    row_d   = row_q;
    col_d   = col_q;
    done_d  = 1'b0;
    if (start_i) begin
      run_d   = 1'b1;
      whole_d = whole_i;
      row_d   = whole_i ? 5'd0 : row_i;
      col_d   = 7'd0;
    end else if (run_q) begin
      if (col_q != LAST_COL) begin
        col_d = col_q + 7'd1;
      end else begin
        col_d = 7'd0;
        // Only the whole-screen mode advances rows; the last row ends it
        if (whole_q && (row_q != LAST_ROW)) begin
          row_d = row_q + 5'd1;
        end else begin
          run_d  = 1'b0;
          done_d = 1'b1;
        end
      end
    end else begin
      run_d = 1'b0;
    end
  end

  // Counter registers; reset starts a full-screen clear at address 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q   <= 1'b1;
      whole_q <= 1'b1;
      row_q   <= 5'd0;
      col_q   <= 7'd0;
      done_q  <= 1'b0;
    end else begin
      run_q   <= run_d;
      whole_q <= whole_d;
      row_q   <= row_d;
      col_q   <= col_d;
      done_q  <= done_d;
    end
  end

  assign active_o = run_q;
  assign row_o    = row_q;
  assign col_o    = col_q;
  assign done_o   = done_q;

endmodule

// File: rtl/text_console_ctrl.sv
// ---------------------------------------------------------------------------
// text_console_ctrl
// Write-side controller for the 80x30 text tile RAM. Accepts ASCII over a
// valid/ready handshake, owns the cursor and turns characters and control
// codes into tile-RAM writes (print, newline, backspace, row/screen clear).
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   ch_data/ch_valid    incoming character and its valid
//   ch_ready            high only in IDLE
//   we, addr_w, din     registered tile RAM port-A write ({row,col}, code)
//   cur_x, cur_y        cursor column/row
//   busy                high while any clear is in progress
// ---------------------------------------------------------------------------
module text_console_ctrl
  import text_console_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  ch_data,
  input  logic        ch_valid,
  output logic        ch_ready,
  output logic        we,
  output logic [11:0] addr_w,
  output logic [6:0]  din,
  output logic [6:0]  cur_x,
  output logic [4:0]  cur_y,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [6:0]  cur_x_q, cur_x_d;
  logic [4:0]  cur_y_q, cur_y_d;
  logic        we_q,    we_d;
  logic [11:0] addr_q,  addr_d;
  logic [6:0]  din_q,   din_d;

  logic        start_s;
  logic        whole_s;
  logic [4:0]  nrow_s;
  logic        clr_active_s;
  logic [4:0]  clr_row_s;
  logic [6:0]  clr_col_s;
  logic        clr_done_s;
  logic        xfer_s;

  assign ch_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign xfer_s   = ch_valid && ch_ready;
  assign nrow_s   = next_row(cur_y_q);

  tile_clear_seq u_clear_seq (
    .clk      (clk),
    .reset    (reset),
    .start_i  (start_s),
    .whole_i  (whole_s),
    .row_i    (nrow_s),
    .active_o (clr_active_s),
    .row_o    (clr_row_s),
    .col_o    (clr_col_s),
    .done_o   (clr_done_s)
  );

  // FSM next state, cursor update, character decode and write-port values
  always_comb begin
    state_d = state_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    din_d   = din_q;
    start_s = 1'b0;
    whole_s = 1'b0;
    case (state_q)
      CLR_ALL, CLR_ROW: begin
        if (clr_active_s) begin
          we_d   = 1'b1;
          addr_d = {clr_row_s, clr_col_s};
          din_d  = BLANK;
        end else begin
          we_d = 1'b0;
        end
        // done arrives the cycle the last clear write is on the port
        if (clr_done_s) begin
          state_d = IDLE;
        end else begin
          state_d = state_q;
        end
      end
      IDLE: begin
        if (xfer_s) begin
          if (is_printable(ch_data)) begin
            we_d   = 1'b1;
            addr_d = {cur_y_q, cur_x_q};
            din_d  = ch_data;
            if (cur_x_q == LAST_COL) begin
              // Character lands this write; row clear of the next row follows
              cur_x_d = 7'd0;
              cur_y_d = nrow_s;
              start_s = 1'b1;
              whole_s = 1'b0;
              state_d = CLR_ROW;
            end else begin
              cur_x_d = cur_x_q + 7'd1;
            end
          end else begin
            case (ch_data)
              CH_LF, CH_CR: begin
                cur_x_d = 7'd0;
                cur_y_d = nrow_s;
                start_s = 1'b1;
                whole_s = 1'b0;
                state_d = CLR_ROW;
              end
              CH_BS: begin
                if (cur_x_q != 7'd0) begin
                  cur_x_d = cur_x_q - 7'd1;
                  we_d    = 1'b1;
                  addr_d  = {cur_y_q, cur_x_q - 7'd1};
                  din_d   = BLANK;
                end else begin
                  cur_x_d = cur_x_q;
                end
              end
              CH_FF: begin
                cur_x_d = 7'd0;
                cur_y_d = 5'd0;
                start_s = 1'b1;
                whole_s = 1'b1;
                state_d = CLR_ALL;
              end
              default: begin
                state_d = IDLE;
              end
            endcase
          end
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = CLR_ALL;
      end
    endcase
  end

  // State, cursor and registered write port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CLR_ALL;
      cur_x_q <= 7'd0;
      cur_y_q <= 5'd0;
      we_q    <= 1'b0;
      addr_q  <= 12'd0;
      din_q   <= 7'd0;
    end else begin
      state_q <= state_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

  assign we     = we_q;
  assign addr_w = addr_q;
  assign din    = din_q;
  assign cur_x  = cur_x_q;
  assign cur_y  = cur_y_q;

endmodule

// File: tb/tb_text_console_ctrl.sv
module tb_text_console_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  ch_data;
  logic        ch_valid;
  logic        ch_ready;
  logic        we;
  logic [11:0] addr_w;
  logic [6:0]  din;
  logic [6:0]  cur_x;
  logic [4:0]  cur_y;
  logic        busy;

  text_console_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .ch_data  (ch_data),
    .ch_valid (ch_valid),
    .ch_ready (ch_ready),
    .we       (we),
    .addr_w   (addr_w),
    .din      (din),
    .cur_x    (cur_x),
    .cur_y    (cur_y),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Image of the tile RAM as seen on the write port
  logic [6:0] vram [0:4095];
  int         illegal_w = 0;

  always @(negedge clk) begin
    if (we === 1'b1) begin
      vram[addr_w] <= din;
      if ((int'(addr_w[6:0]) >= 80) || (int'(addr_w[11:7]) >= 30))
        illegal_w <= illegal_w + 1;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timeout waiting for DUT", nm);
  endtask

  // Address following p in screen order, wrapping the row count
  function automatic int next_addr(input int p);
    int r, c;
    r = p / 128;
    c = p % 128;
    if (c == 79) begin
      c = 0;
      r = (r + 1) % 30;
    end else begin
      c = c + 1;
    end
    return r * 128 + c;
  endfunction

  // Behavioural screen model
  logic [6:0] scr [0:29][0:79];
  int mx, my;

  function automatic void model_clear_all();
    for (int y = 0; y < 30; y++)
      for (int x = 0; x < 80; x++)
        scr[y][x] = 7'h20;
  endfunction

  function automatic void model_newline();
    mx = 0;
    my = (my + 1) % 30;
    for (int x = 0; x < 80; x++) scr[my][x] = 7'h20;
  endfunction

  function automatic void model_apply(input logic [6:0] c);
    int ci;
    ci = int'(c);
    if (ci >= 32 && ci <= 126) begin
      scr[my][mx] = c;
      if (mx == 79) model_newline();
      else mx = mx + 1;
    end else if (ci == 10 || ci == 13) begin
      model_newline();
    end else if (ci == 8) begin
      if (mx > 0) begin
        mx = mx - 1;
        scr[my][mx] = 7'h20;
      end
    end else if (ci == 12) begin
      mx = 0;
      my = 0;
      model_clear_all();
    end
  endfunction

  task automatic wait_ready();
    int g;
    g = 0;
    while (ch_ready !== 1'b1 && g < 6000) begin
      @(negedge clk);
      g++;
    end
    if (ch_ready !== 1'b1) timeout("wait_ready");
  endtask

  // Watch the write port until the controller is idle with no write pending
  task automatic observe(output int nw, output int a_first, output int d_first,
                         output int a_last, output int rdy_low,
                         output int bad_blank, output int seq_err);
    int prev, guard;
    nw = 0; a_first = -1; d_first = -1; a_last = -1;
    rdy_low = 0; bad_blank = 0; seq_err = 0; prev = 0; guard = 0;
    forever begin
      @(negedge clk);
      guard++;
      if (we === 1'b1) begin
        if (nw == 0) begin
          a_first = int'(addr_w);
          d_first = int'(din);
        end else begin
          if (din !== 7'h20) bad_blank++;
          if (int'(addr_w) != next_addr(prev)) seq_err++;
        end
        prev   = int'(addr_w);
        a_last = int'(addr_w);
        nw++;
      end
      if (ch_ready !== 1'b1) rdy_low++;
      if (ch_ready === 1'b1 && we === 1'b0) break;
      if (guard > 6000) begin
        timeout("observe");
        break;
      end
    end
  endtask

  task automatic send_obs(input logic [6:0] c, output int nw, output int a_first,
                          output int d_first, output int a_last, output int rdy_low,
                          output int bad_blank, output int seq_err);
    wait_ready();
    ch_data  = c;
    ch_valid = 1'b1;
    @(posedge clk);
    #1 ch_valid = 1'b0;
    observe(nw, a_first, d_first, a_last, rdy_low, bad_blank, seq_err);
  endtask

  typedef struct {
    logic [6:0] ch;
    int nw; int a_first; int d_first; int a_last; int rdy; int ex; int ey;
  } vec_t;

  vec_t tbl [10];
  int nw, af, df, al, rl, bb, se;

  initial begin
    int cnt, g, r, mism;
    logic [6:0] c;

    tbl[0] = '{7'h43, 1, 'h002, 'h43, 'h002, 0, 3, 0};
    tbl[1] = '{7'h08, 1, 'h002, 'h20, 'h002, 0, 2, 0};
    tbl[2] = '{7'h01, 0, -1, -1, -1, 0, 2, 0};
    tbl[3] = '{7'h7F, 0, -1, -1, -1, 0, 2, 0};
    tbl[4] = '{7'h0D, 80, 'h080, 'h20, 'h0CF, 81, 0, 1};
    tbl[5] = '{7'h08, 0, -1, -1, -1, 0, 0, 1};
    tbl[6] = '{7'h7E, 1, 'h080, 'h7E, 'h080, 0, 1, 1};
    tbl[7] = '{7'h20, 1, 'h081, 'h20, 'h081, 0, 2, 1};
    tbl[8] = '{7'h0A, 80, 'h100, 'h20, 'h14F, 81, 0, 2};
    tbl[9] = '{7'h1B, 0, -1, -1, -1, 0, 0, 2};

    reset    = 1'b1;
    ch_valid = 1'b0;
    ch_data  = 7'h00;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_we", int'(we), 0);
    chk("rst_addr", int'(addr_w), 0);
    chk("rst_din", int'(din), 0);
    chk("rst_ready", int'(ch_ready), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_cur_x", int'(cur_x), 0);
    chk("rst_cur_y", int'(cur_y), 0);

    // Power-up full clear
    reset = 1'b0;
    observe(nw, af, df, al, rl, bb, se);
    chk("init_nw", nw, 2400);
    chk("init_first", af, 'h000);
    chk("init_din", df, 'h20);
    chk("init_last", al, 'hECF);
    chk("init_blank", bb, 0);
    chk("init_seq", se, 0);
    chk("init_ready", int'(ch_ready), 1);
    chk("init_busy", int'(busy), 0);
    chk("init_cur", int'(cur_x) + 128 * int'(cur_y), 0);

    // Back-to-back 'A','B'
    ch_data  = 7'h41;
    ch_valid = 1'b1;
    @(posedge clk);
    #1 ch_data = 7'h42;
    @(negedge clk);
    chk("ab_we0", int'(we), 1);
    chk("ab_addr0", int'(addr_w), 'h000);
    chk("ab_din0", int'(din), 'h41);
    @(posedge clk);
    #1 ch_valid = 1'b0;
    @(negedge clk);
    chk("ab_we1", int'(we), 1);
    chk("ab_addr1", int'(addr_w), 'h001);
    chk("ab_din1", int'(din), 'h42);
    @(negedge clk);
    chk("ab_we_off", int'(we), 0);
    chk("ab_cur_x", int'(cur_x), 2);
    chk("ab_cur_y", int'(cur_y), 0);

    // Table of single characters from (2,0)
    for (int i = 0; i < 10; i++) begin
      send_obs(tbl[i].ch, nw, af, df, al, rl, bb, se);
      chk($sformatf("vec%0d_nw", i), nw, tbl[i].nw);
      chk($sformatf("vec%0d_first", i), af, tbl[i].a_first);
      chk($sformatf("vec%0d_din", i), df, tbl[i].d_first);
      chk($sformatf("vec%0d_last", i), al, tbl[i].a_last);
      chk($sformatf("vec%0d_rdylow", i), rl, tbl[i].rdy);
      chk($sformatf("vec%0d_blank", i), bb, 0);
      chk($sformatf("vec%0d_cur_x", i), int'(cur_x), tbl[i].ex);
      chk($sformatf("vec%0d_cur_y", i), int'(cur_y), tbl[i].ey);
    end

    // Form feed, then 80 printables wrapping to row 1
    send_obs(7'h0C, nw, af, df, al, rl, bb, se);
    chk("ff_nw", nw, 2400);
    chk("ff_first", af, 'h000);
    chk("ff_last", al, 'hECF);
    chk("ff_rdylow", rl, 2401);
    chk("ff_cur", int'(cur_x) + 128 * int'(cur_y), 0);
    for (int i = 0; i < 79; i++)
      send_obs(7'h41 + 7'(i % 26), nw, af, df, al, rl, bb, se);
    chk("pre_wrap_x", int'(cur_x), 79);
    send_obs(7'h5A, nw, af, df, al, rl, bb, se);
    chk("wrap_nw", nw, 81);
    chk("wrap_first", af, 'h04F);
    chk("wrap_din", df, 'h5A);
    chk("wrap_last", al, 'h0CF);
    chk("wrap_rdylow", rl, 81);
    chk("wrap_blank", bb, 0);
    chk("wrap_seq", se, 0);
    chk("wrap_cur_x", int'(cur_x), 0);
    chk("wrap_cur_y", int'(cur_y), 1);

    // Newline from the last row wraps to row 0
    for (int i = 0; i < 28; i++)
      send_obs(7'h0A, nw, af, df, al, rl, bb, se);
    chk("row29_y", int'(cur_y), 29);
    send_obs(7'h0A, nw, af, df, al, rl, bb, se);
    chk("lf29_nw", nw, 80);
    chk("lf29_first", af, 'h000);
    chk("lf29_din", df, 'h20);
    chk("lf29_last", al, 'h04F);
    chk("lf29_blank", bb, 0);
    chk("lf29_cur", int'(cur_x) + 128 * int'(cur_y), 0);

    // Backspace at (5,3) and at (0,3)
    for (int i = 0; i < 3; i++)
      send_obs(7'h0A, nw, af, df, al, rl, bb, se);
    for (int i = 0; i < 5; i++)
      send_obs(7'h61 + 7'(i), nw, af, df, al, rl, bb, se);
    send_obs(7'h08, nw, af, df, al, rl, bb, se);
    chk("bs_nw", nw, 1);
    chk("bs_addr", af, 'h184);
    chk("bs_din", df, 'h20);
    chk("bs_cur_x", int'(cur_x), 4);
    chk("bs_cur_y", int'(cur_y), 3);
    for (int i = 0; i < 4; i++)
      send_obs(7'h08, nw, af, df, al, rl, bb, se);
    send_obs(7'h08, nw, af, df, al, rl, bb, se);
    chk("bs0_nw", nw, 0);
    chk("bs0_cur_x", int'(cur_x), 0);
    chk("bs0_cur_y", int'(cur_y), 3);

    // Reset in the middle of a form-feed clear
    wait_ready();
    ch_data  = 7'h0C;
    ch_valid = 1'b1;
    @(posedge clk);
    #1 ch_valid = 1'b0;
    cnt = 0;
    g   = 0;
    while (cnt < 100 && g < 500) begin
      @(negedge clk);
      g++;
      if (we === 1'b1) cnt++;
    end
    chk("mid_cnt", cnt, 100);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_we", int'(we), 0);
    chk("mid_rst_addr", int'(addr_w), 0);
    chk("mid_rst_busy", int'(busy), 1);
    @(negedge clk);
    reset = 1'b0;
    observe(nw, af, df, al, rl, bb, se);
    chk("rerun_nw", nw, 2400);
    chk("rerun_first", af, 'h000);
    chk("rerun_last", al, 'hECF);
    chk("rerun_blank", bb, 0);
    chk("rerun_seq", se, 0);
    chk("rerun_cur", int'(cur_x) + 128 * int'(cur_y), 0);

    // Random stream against the screen model
    model_clear_all();
    mx = 0;
    my = 0;
    for (int k = 0; k < 400; k++) begin
      r = int'($urandom_range(0, 99));
      if (r < 60)      c = 7'($urandom_range(32, 126));
      else if (r < 70) c = 7'h0A;
      else if (r < 76) c = 7'h0D;
      else if (r < 88) c = 7'h08;
      else if (r < 89) c = 7'h0C;
      else begin
        c = 7'($urandom_range(0, 31));
        if (c == 7'h08 || c == 7'h0A || c == 7'h0C || c == 7'h0D) c = 7'h7F;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      wait_ready();
      ch_data  = c;
      ch_valid = 1'b1;
      @(posedge clk);
      model_apply(c);
      #1 ch_valid = 1'b0;
    end
    @(negedge clk);
    wait_ready();
    repeat (3) @(negedge clk);
    mism = 0;
    for (int y = 0; y < 30; y++)
      for (int x = 0; x < 80; x++)
        if (vram[y * 128 + x] !== scr[y][x]) mism++;
    chk("rand_screen", mism, 0);
    chk("rand_cur_x", int'(cur_x), mx);
    chk("rand_cur_y", int'(cur_y), my);
    chk("illegal_writes", illegal_w, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
